// File: rtl/serv_rf_ram_banked_if.sv
// Request/response bundle between serv_rf_ram_if and the banked register-file RAM.
// aw must equal $clog2(depth) of the attached RAM.
interface serv_rf_ram_banked_if #(
   parameter int width = 8,
   parameter int aw    = 8
);
   logic [aw-1:0]    i_waddr;
   logic [width-1:0] i_wdata;
   logic             i_wen;
   logic [aw-1:0]    i_raddr;
   logic             i_ren;
   logic [width-1:0] o_rdata;
   logic             o_ready;

   modport master (output i_waddr, i_wdata, i_wen, i_raddr, i_ren,
                   input  o_rdata, o_ready);
   modport slave  (input  i_waddr, i_wdata, i_wen, i_raddr, i_ren,
                   output o_rdata, o_ready);
endinterface

// File: rtl/serv_rf_ram_banked.sv
// SERV register-file RAM spread across 256x8 SRAM macros with per-bank chip enables,
// read-data hold, x0/out-of-range gating and an optional post-reset zero sweep.

// Behavioural stand-in for the foundry macro: active-low enables, per-bit write mask.
module gf180mcu_fd_ip_sram__sram256x8m8wm1 (
   input  wire        CLK,
   input  wire        CEN,
   input  wire        GWEN,
   input  wire  [7:0] WEN,
   input  wire  [7:0] A,
   input  wire  [7:0] D,
   output logic [7:0] Q,
   input  wire        VDD,
   input  wire        VSS
);
   logic [7:0] mem [256];
   wire        powered = VDD & ~VSS;

   always_ff @(posedge CLK) begin
      if (!CEN && powered) begin
         if (!GWEN) begin
            for (int i = 0; i < 8; i++)
               if (!WEN[i]) mem[A][i] <= D[i];
         end else begin
            Q <= mem[A];
         end
      end
   end
endmodule

module serv_rf_ram_banked #(
   parameter int width          = 8,
   parameter int csr_regs       = 4,
   parameter int depth          = 32*(32+csr_regs)/width,
   parameter int macro_depth    = 256,
   parameter int banks          = (depth + macro_depth - 1) / macro_depth,
   parameter bit clear_on_reset = 1'b1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   serv_rf_ram_banked_if.slave bus
);
   localparam int          AW        = $clog2(depth);
   localparam int          BW        = (banks > 1) ? $clog2(banks) : 1;
   localparam int          X0_LSB    = 5 - $clog2(width);
   localparam logic [AW:0] DEPTH_W   = (AW+1)'(depth);
   localparam logic [AW:0] LAST      = (AW+1)'(depth - 1);
   localparam logic [7:0]  LANE_MASK = 8'((1 << width) - 1);

   generate
      if (width != 2 && width != 4 && width != 8) begin : g_bad_width
         $error("serv_rf_ram_banked: width must be 2, 4 or 8");
      end
   endgenerate

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t           state_reg, state_next;
   logic [AW:0]      cnt_reg, cnt_next;
   logic             rd_pending_reg;
   logic             rd_zero_reg;
   logic [BW-1:0]    rd_bank_reg;
   logic [width-1:0] hold_reg;

   logic             clearing, ready, wr_en, rd_req, rd_en, rd_zero, acc_wr;
   logic [AW-1:0]    acc_addr;
   logic [BW-1:0]    acc_bank;
   logic [7:0]       acc_a, d_word, wen_word;
   wire  [banks-1:0] cen_n;
   logic [7:0]       q_bank [banks];
   logic [7:0]       rd_q;
   logic [width-1:0] rd_gated;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_CLEAR: begin
            cnt_next = cnt_reg + (AW+1)'(1);
            if (cnt_reg == LAST) state_next = ST_IDLE;
         end
         default: ;
      endcase
   end

   // Write beats read; out-of-range writes never reach a macro.
   always_comb begin
      clearing = !i_rst && (state_reg == ST_CLEAR);
      ready    = !i_rst && (state_reg == ST_IDLE);
      wr_en    = ready && bus.i_wen && ({1'b0, bus.i_waddr} < DEPTH_W);
      rd_req   = ready && !bus.i_wen && bus.i_ren;
      rd_en    = rd_req && ({1'b0, bus.i_raddr} < DEPTH_W);
      rd_zero  = (bus.i_raddr[AW-1:X0_LSB] == '0) || ({1'b0, bus.i_raddr} >= DEPTH_W);
      acc_wr   = clearing || wr_en;
      acc_addr = clearing ? cnt_reg[AW-1:0] : (bus.i_wen ? bus.i_waddr : bus.i_raddr);
      acc_bank = BW'(acc_addr / macro_depth);
      acc_a    = 8'(acc_addr % macro_depth);
      d_word   = clearing ? 8'h00 : 8'(bus.i_wdata);
      wen_word = acc_wr ? ~LANE_MASK : 8'hFF;
   end

   generate
      for (genvar gi = 0; gi < banks; gi++) begin : g_bank
         assign cen_n[gi] = !((acc_wr || rd_en) && (acc_bank == BW'(gi)));

         gf180mcu_fd_ip_sram__sram256x8m8wm1 u_sram (
            .CLK  (i_clk),
            .CEN  (cen_n[gi]),
            .GWEN (!acc_wr),
            .WEN  (wen_word),
            .A    (acc_a),
            .D    (d_word),
            .Q    (q_bank[gi]),
            .VDD  (1'b1),
            .VSS  (1'b0)
         );
      end
   endgenerate

   always_comb begin
      rd_q = 8'h00;
      for (int b = 0; b < banks; b++)
         if (rd_bank_reg == BW'(b)) rd_q = q_bank[b];
      rd_gated = rd_zero_reg ? '0 : rd_q[width-1:0];
   end

   // Upper macro lanes are never written, so their read bits carry no data.
   generate
      if (width < 8) begin : g_pad
         wire unused_q_hi = ^rd_q[7:width];
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= clear_on_reset ? ST_CLEAR : ST_IDLE;
         cnt_reg        <= '0;
         hold_reg       <= '0;
         rd_pending_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         rd_pending_reg <= rd_req;
         if (rd_pending_reg) hold_reg <= rd_gated;
      end
      rd_zero_reg <= rd_zero;
      rd_bank_reg <= acc_bank;
   end

   assign bus.o_rdata = rd_pending_reg ? rd_gated : hold_reg;
   assign bus.o_ready = ready;
endmodule
